seg_display_monitor: RTL and testbench
======================================

Name: seg_display_monitor

Overview:
- Read-back end of the panel display path: View writes the 8-bit segment patterns out_showL/out_showR; this block samples the same two buses and decodes them back to digit codes and a binary value.
- Requires a pattern to stay stable before accepting it, and pulses update when the accepted display changes.
- Used by STController-side self-check logic and by the verification bench as a display scoreboard tap.

Parameters:
STABLE_CNT, 4, number of consecutive sample_en ticks with an identical 16-bit pattern required before it is accepted (legal range 1-15)

Ports:
cp  input  1  clock
reset  input  1  asynchronous active-high reset
seg_l  input  8  left segment pattern, {dp,g,f,e,d,c,b,a}, 1 = segment lit
seg_r  input  8  right segment pattern, same encoding
sample_en  input  1  sample strobe; one tick = one cycle with sample_en=1
digit_l  output  4  accepted left code: 0-9 digit, 4'hF blank, 4'hE invalid
digit_r  output  4  accepted right code, same coding
dp_l  output  1  accepted left dp bit
dp_r  output  1  accepted right dp bit
value  output  7  binary display value, 0-99
value_valid  output  1  value is meaningful
update  output  1  one-cycle pulse when a new pattern is accepted
seg_err  output  1  accepted pattern contains an invalid side
err_count  output  8  number of accepted patterns with an invalid side, saturating at 255

Behaviour:
- Reset values: digit_l=digit_r=4'hF; dp_l, dp_r, value, value_valid, update, seg_err, err_count all 0. Internal: cand=0, cnt=0, state=S_WAIT.
- Capture: r_seg <= {seg_l,seg_r} every cp edge, with no gating. Comparisons use r_seg only.
- On a sample tick:
  - r_seg == cand: cnt <= min(cnt+1, STABLE_CNT).
  - r_seg != cand: cand <= r_seg, cnt <= 1.
- Acceptance fires on the tick where the new cnt first equals STABLE_CNT, and when either:
  - state==S_WAIT, or
  - cand differs from the committed 16-bit pattern (dp bits included).
- On the edge ending the accepting tick:
  - all decoded outputs load;
  - update=1 for exactly one cycle;
  - state goes to S_STABLE.
- Non-tick cycles hold cnt and cand.
- States:
  - S_WAIT: no commit yet since reset. The first stable pattern always commits, including blank/blank.
  - S_SETTLE: cand differs from the committed pattern and cnt < STABLE_CNT.
  - S_STABLE: cand equals the committed pattern.
  - A differing tick moves S_STABLE to S_SETTLE.
  - Returning to the committed pattern before acceptance moves S_SETTLE back to S_STABLE with no update.
- Latency: with continuous sample_en, update rises on the (STABLE_CNT+1)th edge after the inputs change.
- Decode: exact match only, after masking dp.
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 decodes to blank (F). Any other pattern decodes to invalid (E).
- value / value_valid:
  - Both sides digits: value = 10*digit_l + digit_r (7-bit result, max 99), value_valid=1.
  - Left blank, right digit: value = digit_r, value_valid=1.
  - Otherwise: value=0, value_valid=0.
- Errors:
  - seg_err reloads on every commit.
  - err_count increments once per commit with either side invalid; it holds at 255.
- Glitches shorter than STABLE_CNT ticks never produce update.
- Reset mid-settle discards cand and cnt. The next acceptance needs a full STABLE_CNT ticks and is treated as a first commit.

Decomposition:
- Package seg_display_pkg:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - code constants CODE_BLANK=4'hF and CODE_INVALID=4'hE;
  - state enum {S_WAIT, S_SETTLE, S_STABLE}.
- Sub-module seg7_decode: combinational, 8-bit pattern -> 4-bit code plus dp. Instantiated twice, on cand[15:8] and cand[7:0].

Test Plan:
- Reset asserted asynchronously between edges -> outputs immediately at reset values; update stays 0 while reset is high.
- seg_l=5B, seg_r=6D, sample_en=1 continuous, STABLE_CNT=4 -> update on the 5th edge; digit_l=2, digit_r=5, value=25, value_valid=1.
- From accepted 25, change seg_r to 4F for 2 ticks, then back to 6D -> no update; outputs still 25.
- seg_l=06, seg_r=49 held 4 ticks -> digit_r=E, seg_err=1, err_count=1, value_valid=0, value=0. Repeat with seg_r=48 -> err_count=2.
- seg_l=00, seg_r=87 (dp set) with sample_en every 3rd cycle -> update after the 4th tick; digit_l=F, digit_r=7, dp_r=1, value=7, value_valid=1.
- Reset pulsed at cnt=3 during settle to 3F/3F -> no update. After release, update fires only after 4 further ticks; value=0, value_valid=1.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants and types for the segment display read-back monitor.
package seg_display_pkg;

  // Segment patterns with dp masked off, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_STABLE
  } state_t;

  function automatic logic isDigit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/seg_display_monitor_if.sv
// Bundle of the sampled segment buses and the decoded read-back results.
interface seg_display_monitor_if;
  logic [7:0] seg_l;
  logic [7:0] seg_r;
  logic       sample_en;
  logic [3:0] digit_l;
  logic [3:0] digit_r;
  logic       dp_l;
  logic       dp_r;
  logic [6:0] value;
  logic       value_valid;
  logic       update;
  logic       seg_err;
  logic [7:0] err_count;

  modport master (
    output seg_l, seg_r, sample_en,
    input  digit_l, digit_r, dp_l, dp_r, value, value_valid, update, seg_err, err_count
  );

  modport slave (
    input  seg_l, seg_r, sample_en,
    output digit_l, digit_r, dp_l, dp_r, value, value_valid, update, seg_err, err_count
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to digit code decoder; exact matches only.
module seg7_decode
  import seg_display_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] code,
  output logic       dp
);

  // Map the dp-masked pattern to 0-9, blank or invalid.
  always_comb begin
    dp   = pattern[7];
    code = CODE_INVALID;
    case (pattern[6:0])
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_display_monitor.sv
// Samples the two display segment buses, waits for a stable pattern and
// decodes the accepted display back to digit codes and a binary value.
//
// state    | meaning
// S_WAIT   | nothing committed since reset; first stable pattern commits
// S_SETTLE | candidate differs from committed pattern, not yet stable
// S_STABLE | candidate equals the committed pattern
module seg_display_monitor
  import seg_display_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic cp,
  input  logic reset,
  seg_display_monitor_if.slave bus
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CNT);

  logic [15:0] rSeg;
  logic [15:0] cand;
  logic [15:0] candNext;
  logic [15:0] committed;
  logic [3:0]  cnt;
  logic [3:0]  cntNext;
  logic        tick;
  logic        reachStable;
  logic        accept;
  state_t      stateQ;
  state_t      stateNext;

  logic [3:0]  codeL;
  logic [3:0]  codeR;
  logic        dpL;
  logic        dpR;
  logic [6:0]  valueNext;
  logic        validNext;
  logic        errNext;

  logic [3:0]  digitLQ;
  logic [3:0]  digitRQ;
  logic        dpLQ;
  logic        dpRQ;
  logic [6:0]  valueQ;
  logic        validQ;
  logic        updateQ;
  logic        segErrQ;
  logic [7:0]  errCountQ;

  assign tick = bus.sample_en;

  // Candidate tracking: restart on a new pattern, count up to STABLE_CNT on repeats.
  always_comb begin
    candNext    = cand;
    cntNext     = cnt;
    reachStable = 1'b0;
    if (tick) begin
      if (rSeg == cand) begin
        cntNext     = (cnt >= STABLE_N) ? STABLE_N : cnt + 4'd1;
        reachStable = (cnt != STABLE_N) && (cntNext == STABLE_N);
      end else begin
        candNext    = rSeg;
        cntNext     = 4'd1;
        reachStable = (STABLE_N == 4'd1);
      end
    end
  end

  // Decoders look at the candidate being written this cycle, which equals
  // cand itself whenever acceptance follows a repeat.
  seg7_decode uDecodeL (.pattern(candNext[15:8]), .code(codeL), .dp(dpL));
  seg7_decode uDecodeR (.pattern(candNext[7:0]),  .code(codeR), .dp(dpR));

  // State register.
  always_ff @(posedge cp or posedge reset) begin
    if (reset) stateQ <= S_WAIT;
    else       stateQ <= stateNext;
  end

  // Next state: any tick after the first commit re-evaluates against the committed pattern.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      S_WAIT: begin
        if (reachStable) stateNext = S_STABLE;
      end
      S_SETTLE, S_STABLE: begin
        if (tick) begin
          stateNext = (reachStable || candNext == committed) ? S_STABLE : S_SETTLE;
        end
      end
      default: stateNext = S_WAIT;
    endcase
  end

  // Commit decision: a newly stable pattern commits on the first lock or when it differs.
  always_comb begin
    accept = 1'b0;
    case (stateQ)
      S_WAIT:             accept = reachStable;
      S_SETTLE, S_STABLE: accept = reachStable && (candNext != committed);
      default:            accept = 1'b0;
    endcase
  end

  // Value and error derived from the two decoded codes.
  always_comb begin
    valueNext = 7'd0;
    validNext = 1'b0;
    if (isDigit(codeL) && isDigit(codeR)) begin
      valueNext = 7'(codeL) * 7'd10 + 7'(codeR);
      validNext = 1'b1;
    end else if (codeL == CODE_BLANK && isDigit(codeR)) begin
      valueNext = 7'(codeR);
      validNext = 1'b1;
    end
    errNext = (codeL == CODE_INVALID) || (codeR == CODE_INVALID);
  end

  // Sampling, candidate counter and committed outputs.
  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      rSeg      <= 16'h0000;
      cand      <= 16'h0000;
      cnt       <= 4'd0;
      committed <= 16'h0000;
      digitLQ   <= CODE_BLANK;
      digitRQ   <= CODE_BLANK;
      dpLQ      <= 1'b0;
      dpRQ      <= 1'b0;
      valueQ    <= 7'd0;
      validQ    <= 1'b0;
      updateQ   <= 1'b0;
      segErrQ   <= 1'b0;
      errCountQ <= 8'd0;
    end else begin
      rSeg    <= {bus.seg_l, bus.seg_r};
      cand    <= candNext;
      cnt     <= cntNext;
      updateQ <= accept;
      if (accept) begin
        committed <= candNext;
        digitLQ   <= codeL;
        digitRQ   <= codeR;
        dpLQ      <= dpL;
        dpRQ      <= dpR;
        valueQ    <= valueNext;
        validQ    <= validNext;
        segErrQ   <= errNext;
        if (errNext && errCountQ != 8'hFF) errCountQ <= errCountQ + 8'd1;
      end
    end
  end

  assign bus.digit_l     = digitLQ;
  assign bus.digit_r     = digitRQ;
  assign bus.dp_l        = dpLQ;
  assign bus.dp_r        = dpRQ;
  assign bus.value       = valueQ;
  assign bus.value_valid = validQ;
  assign bus.update      = updateQ;
  assign bus.seg_err     = segErrQ;
  assign bus.err_count   = errCountQ;

endmodule

// File: tb/tb_seg_display_monitor.sv
// Testbench for seg_display_monitor: directed scenarios plus randomized
// patterns, compared every cycle against a tick-history reference model.
module tb_seg_display_monitor;

  localparam int unsigned STABLE_CNT = 4;

  logic cp = 1'b0;
  logic reset = 1'b1;
  bit   chkEn = 1'b0;

  seg_display_monitor_if bus();

  seg_display_monitor #(.STABLE_CNT(STABLE_CNT)) dut (
    .cp(cp),
    .reset(reset),
    .bus(bus)
  );

  always #5 cp = ~cp;

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkVal(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [6:0]  segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [15:0] mPrev, mLast, mCommit;
  int          mRun;
  bit          mHave;
  int          mDigL, mDigR, mDpL, mDpR, mValue, mValid, mUpd, mErr, mErrCnt;

  function automatic int refCode(input logic [7:0] p);
    for (int i = 0; i < 10; i++) if (p[6:0] == segTab[i]) return i;
    if (p[6:0] == 7'h00) return 15;
    return 14;
  endfunction

  task automatic resetModel();
    mPrev = 0; mLast = 0; mCommit = 0; mRun = 0; mHave = 0;
    mDigL = 15; mDigR = 15; mDpL = 0; mDpR = 0;
    mValue = 0; mValid = 0; mUpd = 0; mErr = 0; mErrCnt = 0;
  endtask

  task automatic commitModel(input logic [15:0] pat);
    int l, r;
    l = refCode(pat[15:8]);
    r = refCode(pat[7:0]);
    mDigL = l; mDigR = r;
    mDpL = int'(pat[15]); mDpR = int'(pat[7]);
    if (l <= 9 && r <= 9) begin mValue = 10 * l + r; mValid = 1; end
    else if (l == 15 && r <= 9) begin mValue = r; mValid = 1; end
    else begin mValue = 0; mValid = 0; end
    mErr = (l == 14 || r == 14) ? 1 : 0;
    if (mErr == 1 && mErrCnt < 255) mErrCnt++;
    mUpd = 1; mHave = 1; mCommit = pat;
  endtask

  task automatic modelStep();
    if (reset) resetModel();
    else begin
      mUpd = 0;
      if (bus.sample_en) begin
        if (mPrev == mLast) mRun++;
        else begin mLast = mPrev; mRun = 1; end
        if (mRun == STABLE_CNT && (!mHave || mLast != mCommit)) commitModel(mLast);
      end
      mPrev = {bus.seg_l, bus.seg_r};
    end
  endtask

  initial begin
    resetModel();
    forever begin
      @(posedge cp or posedge reset);
      modelStep();
    end
  end

  task automatic checkOutputs();
    checkVal("digit_l", int'(bus.digit_l), mDigL);
    checkVal("digit_r", int'(bus.digit_r), mDigR);
    checkVal("dp_l", int'(bus.dp_l), mDpL);
    checkVal("dp_r", int'(bus.dp_r), mDpR);
    checkVal("value", int'(bus.value), mValue);
    checkVal("value_valid", int'(bus.value_valid), mValid);
    checkVal("update", int'(bus.update), mUpd);
    checkVal("seg_err", int'(bus.seg_err), mErr);
    checkVal("err_count", int'(bus.err_count), mErrCnt);
  endtask

  initial forever begin
    @(negedge cp);
    if (chkEn) checkOutputs();
  end

  task automatic setPat(input logic [7:0] l, input logic [7:0] r);
    bus.seg_l = l;
    bus.seg_r = r;
  endtask

  // Runs n cycles from a negedge, sample_en on every period-th cycle; counts update pulses.
  task automatic runCycles(input int n, input int period, output int updates);
    updates = 0;
    for (int i = 0; i < n; i++) begin
      bus.sample_en = ((i % period) == 0);
      @(posedge cp);
      #1;
      if (bus.update) updates++;
      @(negedge cp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_digit_l"}, int'(bus.digit_l), 15);
    checkVal({tag, "_digit_r"}, int'(bus.digit_r), 15);
    checkVal({tag, "_update"}, int'(bus.update), 0);
    checkVal({tag, "_value"}, int'(bus.value), 0);
    checkVal({tag, "_valid"}, int'(bus.value_valid), 0);
    checkVal({tag, "_err_count"}, int'(bus.err_count), 0);
    checkVal({tag, "_seg_err"}, int'(bus.seg_err), 0);
  endtask

  // Called at a negedge: asserts reset between edges, holds over one posedge, releases at negedge.
  task automatic asyncReset(input string tag);
    #2 reset = 1'b1;
    #1 checkResetValues(tag);
    @(negedge cp);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] randSide();
    int k;
    logic [7:0] p;
    k = $urandom_range(0, 15);
    if (k < 10) p = {1'b0, segTab[k]};
    else if (k < 12) p = 8'h00;
    else p = 8'($urandom);
    if ($urandom_range(0, 3) == 0) p[7] = 1'b1;
    return p;
  endfunction

  initial begin
    int u, u2, hold;
    setPat(8'h00, 8'h00);
    bus.sample_en = 1'b0;
    repeat (2) @(negedge cp);
    checkResetValues("por");
    chkEn = 1'b1;
    reset = 1'b0;

    // 25 with continuous ticks: update on the 5th edge
    setPat(8'h5B, 8'h6D);
    for (int k = 1; k <= 5; k++) begin
      bus.sample_en = 1'b1;
      @(posedge cp);
      #1;
      checkVal("lat_update", int'(bus.update), int'(k == 5));
      if (k == 5) begin
        checkVal("s25_digit_l", int'(bus.digit_l), 2);
        checkVal("s25_digit_r", int'(bus.digit_r), 5);
        checkVal("s25_value", int'(bus.value), 25);
        checkVal("s25_valid", int'(bus.value_valid), 1);
      end
      @(negedge cp);
    end
    runCycles(3, 1, u);
    checkVal("hold_updates", u, 0);

    // short glitch on the right side must not commit
    setPat(8'h5B, 8'h4F);
    runCycles(2, 1, u);
    setPat(8'h5B, 8'h6D);
    runCycles(8, 1, u2);
    checkVal("glitch_updates", u + u2, 0);
    checkVal("glitch_value", int'(bus.value), 25);

    // invalid right side
    setPat(8'h06, 8'h49);
    runCycles(6, 1, u);
    checkVal("inv1_updates", u, 1);
    checkVal("inv1_digit_r", int'(bus.digit_r), 14);
    checkVal("inv1_seg_err", int'(bus.seg_err), 1);
    checkVal("inv1_err_count", int'(bus.err_count), 1);
    checkVal("inv1_valid", int'(bus.value_valid), 0);
    checkVal("inv1_value", int'(bus.value), 0);
    setPat(8'h06, 8'h48);
    runCycles(6, 1, u);
    checkVal("inv2_err_count", int'(bus.err_count), 2);

    // blank left, 7 with dp, sparse ticks
    setPat(8'h00, 8'h87);
    runCycles(15, 3, u);
    checkVal("sparse_updates", u, 1);
    checkVal("sparse_digit_l", int'(bus.digit_l), 15);
    checkVal("sparse_digit_r", int'(bus.digit_r), 7);
    checkVal("sparse_dp_r", int'(bus.dp_r), 1);
    checkVal("sparse_value", int'(bus.value), 7);
    checkVal("sparse_valid", int'(bus.value_valid), 1);
    checkVal("sparse_seg_err", int'(bus.seg_err), 0);

    // reset in the middle of settling to 00
    setPat(8'h3F, 8'h3F);
    runCycles(4, 1, u);
    checkVal("mid_updates", u, 0);
    asyncReset("midrst");
    runCycles(4, 1, u);
    checkVal("post_rst_early", u, 0);
    runCycles(1, 1, u);
    checkVal("post_rst_commit", u, 1);
    checkVal("post_rst_value", int'(bus.value), 0);
    checkVal("post_rst_valid", int'(bus.value_valid), 1);
    checkVal("post_rst_digit_l", int'(bus.digit_l), 0);

    // randomized patterns, hold times, tick density and occasional resets
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 2) != 0) setPat(randSide(), randSide());
      hold = $urandom_range(1, 10);
      for (int h = 0; h < hold; h++) begin
        bus.sample_en = ($urandom_range(0, 3) != 0);
        @(posedge cp);
        @(negedge cp);
      end
      if ($urandom_range(0, 49) == 0) asyncReset("rndrst");
    end

    bus.sample_en = 1'b0;
    @(negedge cp);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
